// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, the bubble instruction, the hazard
// FSM state encoding and field-extraction helpers for instruction words.
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BUBBLE = 6'h3F;

  // Word loaded into IF/ID when it is flushed; decodes as OP_BUBBLE.
  localparam logic [31:0] INST_BUBBLE = 32'hff000000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  function automatic logic [5:0] inst_op(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  function automatic logic [4:0] inst_rs(input logic [31:0] inst);
    return inst[25:21];
  endfunction

  function automatic logic [4:0] inst_rt(input logic [31:0] inst);
    return inst[20:16];
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Combinational load-use hazard detector: a lw in ID/EX whose destination
// (rt) is read by the instruction sitting in IF/ID. Shared with the
// forwarding unit, so it carries no state.
module hazard_decode
  import pipe_pkg::*;
(
  input  logic [31:0] ifid_inst,
  input  logic [31:0] idex_inst,
  output logic        lu_hit
);

  logic [5:0] if_op;
  logic [4:0] if_rs;
  logic [4:0] if_rt;
  logic [5:0] ex_op;
  logic [4:0] ex_rt;
  logic       reads_rt;
  logic       unused_bits;

  assign if_op = inst_op(ifid_inst);
  assign if_rs = inst_rs(ifid_inst);
  assign if_rt = inst_rt(ifid_inst);
  assign ex_op = inst_op(idex_inst);
  assign ex_rt = inst_rt(idex_inst);

  // Immediate / rs fields of ID/EX and the low half of IF/ID play no part
  // in hazard detection.
  assign unused_bits = ^{ifid_inst[15:0], idex_inst[25:21], idex_inst[15:0]};

  // rt is a source only for R-type, stores and branches.
  assign reads_rt = (if_op == OP_RTYPE) || (if_op == OP_SW) || (if_op == OP_BEQ);

  // A bubble in IF/ID reads nothing; its rs bits are not a real register.
  always_comb begin
    lu_hit = 1'b0;
    if ((ex_op == OP_LW) && (ex_rt != 5'd0) && (if_op != OP_BUBBLE))
      lu_hit = (ex_rt == if_rs) || (reads_rt && (ex_rt == if_rt));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes and
// data-memory wait states, sequenced by a 4-state FSM with a shared counter.
// Optional build macro HAZ_PERF_CNT_EN adds saturating event counters
// (stall_cnt, flush_cnt, wait_cnt).
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int WAIT_TIMEOUT    = 255,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ifid_inst,
  input  logic [31:0] idex_inst,
  input  logic [31:0] exmem_inst,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_enable,
  output logic        pc_sel_branch,
  output logic        ifid_enable,
  output logic        ifid_flush,
  output logic        idex_nop,
  output logic        exmem_hold,
  output logic        mem_timeout,
`ifdef HAZ_PERF_CNT_EN
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] wait_cnt,
`endif
  output logic [1:0]  state_o
);

  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(LU_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_TIMEOUT);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tmo_n;
  logic             lu_hit;
  logic             run_dec;
  logic             unused_bits;

  // Branch resolution already arrives as branch_taken; the EX/MEM word
  // itself is not needed by this unit.
  assign unused_bits = ^exmem_inst;

  hazard_decode u_decode (
    .ifid_inst (ifid_inst),
    .idex_inst (idex_inst),
    .lu_hit    (lu_hit)
  );

  assign state_o     = state;
  assign run_dec     = (state == ST_RUN) || ((state == ST_WAIT) && !mem_busy);

  // Outputs and next state. The WAIT exit cycle reuses RUN decoding so a
  // branch or hazard pending behind the memory wait is not lost.
  always_comb begin
    pc_enable     = 1'b0;
    pc_sel_branch = 1'b0;
    ifid_enable   = 1'b0;
    ifid_flush    = 1'b0;
    idex_nop      = 1'b0;
    exmem_hold    = 1'b0;
    state_n       = state;
    cnt_n         = cnt;
    tmo_n         = mem_timeout;

    unique case (state)
      ST_FLUSH: begin
        // Wrong-path instruction now in ID is killed; branch_taken is
        // ignored because EX/MEM holds the bubble from the previous cycle.
        idex_nop    = 1'b1;
        pc_enable   = 1'b1;
        ifid_enable = 1'b1;
        state_n     = ST_RUN;
        cnt_n       = '0;
      end
      ST_STALL: begin
        idex_nop = 1'b1;
        if (mem_busy) begin
          // Remaining bubbles dropped; hazard re-evaluates after the wait.
          state_n = ST_WAIT;
          cnt_n   = CNT_W'(1);
        end else if (cnt == STALL_LAST) begin
          state_n = ST_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (mem_busy) begin
          exmem_hold = 1'b1;
          if (cnt >= WAIT_LIMIT) tmo_n = 1'b1;
          if (cnt != '1) cnt_n = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase

    if (run_dec) begin
      cnt_n = '0;
      if ((state == ST_RUN) && mem_busy) begin
        exmem_hold = 1'b1;
        state_n    = ST_WAIT;
        cnt_n      = CNT_W'(1);
      end else if (branch_taken) begin
        // Branch beats a simultaneous load-use: the load is wrong-path.
        // IF/ID capture stays on so the flush bubble is actually loaded.
        pc_sel_branch = 1'b1;
        pc_enable     = 1'b1;
        ifid_enable   = 1'b1;
        ifid_flush    = 1'b1;
        idex_nop      = 1'b1;
        state_n       = ST_FLUSH;
      end else if (lu_hit) begin
        idex_nop = 1'b1;
        if (LU_STALL_CYCLES > 1) begin
          state_n = ST_STALL;
          cnt_n   = CNT_W'(1);
        end else begin
          state_n = ST_RUN;
        end
      end else begin
        pc_enable   = 1'b1;
        ifid_enable = 1'b1;
        state_n     = ST_RUN;
      end
    end

    if (rst) begin
      pc_enable     = 1'b0;
      pc_sel_branch = 1'b0;
      ifid_enable   = 1'b0;
      ifid_flush    = 1'b1;
      idex_nop      = 1'b1;
      exmem_hold    = 1'b0;
    end
  end

  // State, counter and sticky timeout registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mem_timeout <= tmo_n;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic busy_run, stall_evt, flush_evt, wait_evt;

  // Event qualifiers mirror the priority used by the control decode.
  always_comb begin
    busy_run  = (state == ST_RUN) && mem_busy;
    stall_evt = !rst && ((state == ST_STALL) ||
                         (run_dec && !busy_run && !branch_taken && lu_hit));
    flush_evt = !rst && ((state == ST_FLUSH) ||
                         (run_dec && !busy_run && branch_taken));
    wait_evt  = !rst && mem_busy;
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (stall_evt && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_evt && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
      if (wait_evt  && (wait_cnt  != 16'hFFFF)) wait_cnt  <= wait_cnt  + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (1 and 3 load-use
// bubbles) share stimulus; each is compared every cycle against a
// behavioural model of the control rules.
module tb_hazard_ctrl;

  localparam int WT = 255;

  typedef struct packed {
    logic       pc_en;
    logic       pc_sel;
    logic       ifid_en;
    logic       ifid_fl;
    logic       idex_nop;
    logic       hold;
    logic       tmo;
    logic [1:0] st;
  } obs_t;

  // mode: 0 run, 1 stall, 2 flush, 3 wait; left = stall bubbles still owed;
  // streak = consecutive busy cycles seen so far.
  typedef struct packed {
    int mode;
    int left;
    int streak;
    bit tmo;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ifid_inst, idex_inst, exmem_inst;
  logic        branch_taken, mem_busy;

  logic a_pc_en, a_pc_sel, a_if_en, a_if_fl, a_nop, a_hold, a_tmo;
  logic b_pc_en, b_pc_sel, b_if_en, b_if_fl, b_nop, b_hold, b_tmo;
  logic [1:0] a_st, b_st;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  mdl_t m1, m3;

  always #5 clk = ~clk;

  hazard_ctrl #(.LU_STALL_CYCLES(1), .WAIT_TIMEOUT(WT), .CNT_W(8)) u_lu1 (
    .clk(clk), .rst(rst), .ifid_inst(ifid_inst), .idex_inst(idex_inst),
    .exmem_inst(exmem_inst), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_enable(a_pc_en), .pc_sel_branch(a_pc_sel), .ifid_enable(a_if_en),
    .ifid_flush(a_if_fl), .idex_nop(a_nop), .exmem_hold(a_hold),
    .mem_timeout(a_tmo), .state_o(a_st)
  );

  hazard_ctrl #(.LU_STALL_CYCLES(3), .WAIT_TIMEOUT(WT), .CNT_W(8)) u_lu3 (
    .clk(clk), .rst(rst), .ifid_inst(ifid_inst), .idex_inst(idex_inst),
    .exmem_inst(exmem_inst), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_enable(b_pc_en), .pc_sel_branch(b_pc_sel), .ifid_enable(b_if_en),
    .ifid_flush(b_if_fl), .idex_nop(b_nop), .exmem_hold(b_hold),
    .mem_timeout(b_tmo), .state_o(b_st)
  );

  function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 16'h1234};
  endfunction

  // Load-use rule straight from the field definitions.
  function automatic bit ref_lu(input logic [31:0] fi, input logic [31:0] di);
    logic [5:0] fop;
    fop = fi[31:26];
    if (di[31:26] != 6'h23 || di[20:16] == 5'd0) return 1'b0;
    if (fop == 6'h3F) return 1'b0;
    if (di[20:16] == fi[25:21]) return 1'b1;
    if ((fop == 6'h00 || fop == 6'h2B || fop == 6'h04) && di[20:16] == fi[20:16])
      return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step(input mdl_t m, input int nlu, input bit r,
                                     input bit br, input bit busy, input bit lu,
                                     output obs_t e, output mdl_t n);
    n = m;
    e = '0;
    e.st  = 2'(m.mode);
    e.tmo = m.tmo;
    if (r) begin
      e.ifid_fl = 1'b1; e.idex_nop = 1'b1;
      n = '{mode: 0, left: 0, streak: 0, tmo: 1'b0};
    end else if (m.mode == 2) begin
      e.idex_nop = 1'b1; e.pc_en = 1'b1; e.ifid_en = 1'b1;
      n.mode = 0;
    end else if (m.mode == 1) begin
      e.idex_nop = 1'b1;
      if (busy) begin
        n.mode = 3; n.streak = 1;
      end else begin
        n.left = m.left - 1;
        if (n.left == 0) n.mode = 0;
      end
    end else if (m.mode == 3 && busy) begin
      e.hold = 1'b1;
      n.streak = m.streak + 1;
      if (n.streak > WT) n.tmo = 1'b1;
    end else if (m.mode == 0 && busy) begin
      e.hold = 1'b1;
      n.mode = 3; n.streak = 1;
    end else if (br) begin
      e.pc_sel = 1'b1; e.pc_en = 1'b1; e.ifid_en = 1'b1;
      e.ifid_fl = 1'b1; e.idex_nop = 1'b1;
      n.mode = 2;
    end else if (lu) begin
      e.idex_nop = 1'b1;
      if (nlu > 1) begin
        n.mode = 1; n.left = nlu - 1;
      end else begin
        n.mode = 0;
      end
    end else begin
      e.pc_en = 1'b1; e.ifid_en = 1'b1;
      n.mode = 0;
    end
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s @%0t: got %b want %b (pc_en,sel,if_en,if_fl,nop,hold,tmo,st)",
             tag, $time, got, exp);
    end
  endtask

  // One clock cycle: drive, let combinational outputs settle, compare, clock.
  task automatic cyc(input string tag, input bit r, input logic [31:0] fi,
                     input logic [31:0] di, input bit br, input bit busy);
    obs_t e1, e3, o1, o3;
    mdl_t n1, n3;
    bit lu;
    rst = r; ifid_inst = fi; idex_inst = di; branch_taken = br; mem_busy = busy;
    exmem_inst = br ? mk(6'h04, 1, 1) : mk(6'(($urandom % 4) * 8'h0b), 0, 0);
    #2;
    lu = ref_lu(fi, di);
    model_step(m1, 1, r, br, busy, lu, e1, n1);
    model_step(m3, 3, r, br, busy, lu, e3, n3);
    o1 = {a_pc_en, a_pc_sel, a_if_en, a_if_fl, a_nop, a_hold, a_tmo, a_st};
    o3 = {b_pc_en, b_pc_sel, b_if_en, b_if_fl, b_nop, b_hold, b_tmo, b_st};
    check({tag, "/lu1"}, o1, e1);
    check({tag, "/lu3"}, o3, e3);
    m1 = n1; m3 = n3;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] lw9, add9, nop_i, lw0, add0, lw24, bub;
    logic [5:0]  ops [6];
    lw9   = mk(6'h23, 2, 9);
    add9  = mk(6'h00, 9, 3);
    nop_i = mk(6'h00, 1, 2);
    lw0   = mk(6'h23, 2, 0);
    add0  = mk(6'h00, 0, 0);
    lw24  = mk(6'h23, 2, 24);
    bub   = 32'hff000000;
    ops   = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h3F, 6'h08};
    m1 = '{mode: 0, left: 0, streak: 0, tmo: 1'b0};
    m3 = m1;

    // Establish a known state before checking begins.
    rst = 1'b1; ifid_inst = nop_i; idex_inst = nop_i; exmem_inst = nop_i;
    branch_taken = 1'b0; mem_busy = 1'b0;
    @(posedge clk); #1;

    cyc("reset", 1, nop_i, nop_i, 0, 0);
    cyc("idle", 0, nop_i, nop_i, 0, 0);

    // Load-use with rs match: one bubble (lu1) vs three (lu3).
    cyc("lu_a", 0, add9, lw9, 0, 0);
    cyc("lu_b", 0, nop_i, nop_i, 0, 0);
    cyc("lu_c", 0, nop_i, nop_i, 0, 0);
    cyc("lu_d", 0, nop_i, nop_i, 0, 0);
    // Hazard held in place across the whole 3-cycle stall.
    cyc("luh_a", 0, add9, lw9, 0, 0);
    cyc("luh_b", 0, add9, lw9, 0, 0);
    cyc("luh_c", 0, add9, lw9, 0, 0);
    cyc("luh_d", 0, nop_i, nop_i, 0, 0);
    // No hazard: rt=0, or bubble in IF/ID whose rs bits equal the lw rt.
    cyc("rt0", 0, add0, lw0, 0, 0);
    cyc("bubble", 0, bub, lw24, 0, 0);
    cyc("sw_rt", 0, mk(6'h2B, 1, 9), lw9, 0, 0);
    cyc("sw_rt2", 0, nop_i, nop_i, 0, 0);
    cyc("sw_rt3", 0, nop_i, nop_i, 0, 0);
    cyc("lw_rt", 0, mk(6'h23, 1, 9), lw9, 0, 0);

    // Branch with simultaneous hazard; branch_taken repeated in FLUSH.
    cyc("br_0", 0, add9, lw9, 1, 0);
    cyc("br_1", 0, add9, lw9, 1, 0);
    cyc("br_2", 0, nop_i, nop_i, 0, 0);

    // Memory busy for 4 cycles.
    for (int i = 0; i < 4; i++) cyc("busy4", 0, nop_i, nop_i, 0, 1);
    cyc("busy4_rel", 0, nop_i, nop_i, 0, 0);
    cyc("busy4_run", 0, nop_i, nop_i, 0, 0);

    // Busy 256 cycles: timeout sets and stays after release.
    for (int i = 0; i < 256; i++) cyc("busy256", 0, nop_i, nop_i, 0, 1);
    for (int i = 0; i < 3; i++) cyc("tmo_hold", 0, nop_i, nop_i, 0, 0);
    cyc("tmo_rst", 1, nop_i, nop_i, 0, 0);
    cyc("tmo_clr", 0, nop_i, nop_i, 0, 0);

    // Reset while the lu3 instance is in STALL.
    cyc("rs_a", 0, add9, lw9, 0, 0);
    cyc("rs_b", 1, add9, lw9, 0, 0);
    cyc("rs_c", 0, nop_i, nop_i, 0, 0);

    // WAIT exit cycle with a pending branch, then busy during STALL.
    cyc("wx_a", 0, nop_i, nop_i, 0, 1);
    cyc("wx_b", 0, nop_i, nop_i, 1, 0);
    cyc("wx_c", 0, nop_i, nop_i, 0, 0);
    cyc("sb_a", 0, add9, lw9, 0, 0);
    cyc("sb_b", 0, nop_i, nop_i, 0, 1);
    cyc("sb_c", 0, nop_i, nop_i, 0, 0);
    cyc("sb_d", 0, nop_i, nop_i, 0, 0);

    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] fi, di;
      fi = mk(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3));
      di = mk(($urandom_range(0, 1) == 1) ? 6'h23 : ops[$urandom_range(0, 5)],
              $urandom_range(0, 3), $urandom_range(0, 3));
      cyc("rand", ($urandom_range(0, 63) == 0), fi, di,
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
